// File: rtl/alu_execute_unit.sv
// ALU execute unit: single-issue multi-cycle ALU with an IDLE/CALC/DONE
// handshake. Single-cycle arithmetic/logic ops, bit-serial shifts and an
// iterative shift-add multiplier share one set of operand latches.
module alu_execute_unit #(
    parameter int WIDTH = 16
) (
    input  logic             in_clk,
    input  logic             in_rst_n,
    input  logic [WIDTH-1:0] in_operand_1,
    input  logic [WIDTH-1:0] in_operand_2,
    input  logic [2:0]       in_alu_op,
    input  logic             in_start,
    output logic [WIDTH-1:0] out_result,
    output logic             out_busy,
    output logic             out_done,
    output logic [3:0]       out_flags
);

    localparam int SW = $clog2(WIDTH);
    localparam int CW = SW + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_SHL = 3'd5,
        OP_SHR = 3'd6,
        OP_MUL = 3'd7
    } aluOp_t;

    state_t             r_state;
    state_t             w_stateNext;
    aluOp_t             r_op;
    logic [WIDTH-1:0]   r_work;
    logic [WIDTH-1:0]   r_op2;
    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_mcand;
    logic [CW-1:0]      r_count;
    logic [WIDTH-1:0]   r_result;
    logic [3:0]         r_flags;

    logic               w_finish;
    logic [WIDTH-1:0]   w_resNext;
    logic               w_carryNext;
    logic               w_ovfNext;
    logic [WIDTH-1:0]   w_shiftNext;
    logic               w_shiftOut;
    logic [2*WIDTH-1:0] w_accNext;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_diff;
    logic               w_lastIter;

    assign out_result = r_result;
    assign out_flags  = r_flags;

    // State register; reset aborts any operation in flight.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next-state logic plus the status outputs decoded from the state.
    always_comb begin
        w_stateNext = r_state;
        out_busy    = 1'b0;
        out_done    = 1'b0;
        case (r_state)
            IDLE: begin
                if (in_start) begin
                    w_stateNext = CALC;
                end
            end
            CALC: begin
                out_busy = 1'b1;
                if (w_finish) begin
                    w_stateNext = DONE;
                end
            end
            DONE: begin
                out_busy    = 1'b1;
                out_done    = 1'b1;
                w_stateNext = IDLE;
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    // One-step shift and multiply iteration terms from the latched operands.
    always_comb begin
        w_shiftNext = r_work;
        w_shiftOut  = 1'b0;
        if (r_op == OP_SHL) begin
            w_shiftNext = {r_work[WIDTH-2:0], 1'b0};
            w_shiftOut  = r_work[WIDTH-1];
        end else if (r_op == OP_SHR) begin
            w_shiftNext = {1'b0, r_work[WIDTH-1:1]};
            w_shiftOut  = r_work[0];
        end
        w_accNext  = r_op2[0] ? (r_acc + r_mcand) : r_acc;
        w_sum      = {1'b0, r_work} + {1'b0, r_op2};
        w_diff     = {1'b0, r_work} - {1'b0, r_op2};
        w_lastIter = (r_count <= CW'(1));
    end

    // Result and flag candidates; w_finish marks the final CALC cycle.
    always_comb begin
        w_resNext   = '0;
        w_carryNext = 1'b0;
        w_ovfNext   = 1'b0;
        w_finish    = 1'b0;
        case (r_op)
            OP_ADD: begin
                w_finish    = 1'b1;
                w_resNext   = w_sum[WIDTH-1:0];
                w_carryNext = w_sum[WIDTH];
                w_ovfNext   = (r_work[WIDTH-1] == r_op2[WIDTH-1]) &&
                              (w_sum[WIDTH-1] != r_work[WIDTH-1]);
            end
            OP_SUB: begin
                w_finish    = 1'b1;
                w_resNext   = w_diff[WIDTH-1:0];
                w_carryNext = w_diff[WIDTH];
                w_ovfNext   = (r_work[WIDTH-1] != r_op2[WIDTH-1]) &&
                              (w_diff[WIDTH-1] != r_work[WIDTH-1]);
            end
            OP_AND: begin
                w_finish  = 1'b1;
                w_resNext = r_work & r_op2;
            end
            OP_OR: begin
                w_finish  = 1'b1;
                w_resNext = r_work | r_op2;
            end
            OP_XOR: begin
                w_finish  = 1'b1;
                w_resNext = r_work ^ r_op2;
            end
            OP_SHL, OP_SHR: begin
                w_finish = w_lastIter;
                if (r_count == '0) begin
                    w_resNext   = r_work;
                    w_carryNext = 1'b0;
                end else begin
                    w_resNext   = w_shiftNext;
                    w_carryNext = w_shiftOut;
                end
            end
            OP_MUL: begin
                w_finish    = w_lastIter;
                w_resNext   = w_accNext[WIDTH-1:0];
                w_carryNext = |w_accNext[2*WIDTH-1:WIDTH];
            end
            default: begin
                w_finish = 1'b1;
            end
        endcase
    end

    // Operand latching, per-cycle iteration and registered result/flags.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            r_op     <= OP_ADD;
            r_work   <= '0;
            r_op2    <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_count  <= '0;
            r_result <= '0;
            r_flags  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_start) begin
                        r_op    <= aluOp_t'(in_alu_op);
                        r_work  <= in_operand_1;
                        r_op2   <= in_operand_2;
                        r_acc   <= '0;
                        r_mcand <= {{WIDTH{1'b0}}, in_operand_1};
                        if ((in_alu_op == OP_SHL) || (in_alu_op == OP_SHR)) begin
                            r_count <= {1'b0, in_operand_2[SW-1:0]};
                        end else if (in_alu_op == OP_MUL) begin
                            r_count <= CW'(WIDTH);
                        end else begin
                            r_count <= '0;
                        end
                    end
                end
                CALC: begin
                    if (w_finish) begin
                        r_result <= w_resNext;
                        r_flags  <= {(w_resNext == '0), w_resNext[WIDTH-1],
                                     w_carryNext, w_ovfNext};
                        r_count  <= '0;
                    end else begin
                        r_count <= r_count - CW'(1);
                        if (r_op == OP_MUL) begin
                            r_acc   <= w_accNext;
                            r_mcand <= r_mcand << 1;
                            r_op2   <= r_op2 >> 1;
                        end else begin
                            r_work <= w_shiftNext;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_execute_unit.sv
// Testbench for alu_execute_unit: directed vectors plus randomized ops,
// checked against an arithmetic reference model of the ALU behaviour.
module tb_alu_execute_unit;

    localparam int W = 16;

    logic          in_clk = 1'b0;
    logic          in_rst_n = 1'b1;
    logic [W-1:0]  in_operand_1 = '0;
    logic [W-1:0]  in_operand_2 = '0;
    logic [2:0]    in_alu_op = '0;
    logic          in_start = 1'b0;
    logic [W-1:0]  out_result;
    logic          out_busy;
    logic          out_done;
    logic [3:0]    out_flags;

    int            checks = 0;
    int            errors = 0;
    logic [W-1:0]  prevResult = '0;
    logic [3:0]    prevFlags = '0;

    alu_execute_unit #(.WIDTH(W)) dut (
        .in_clk       (in_clk),
        .in_rst_n     (in_rst_n),
        .in_operand_1 (in_operand_1),
        .in_operand_2 (in_operand_2),
        .in_alu_op    (in_alu_op),
        .in_start     (in_start),
        .out_result   (out_result),
        .out_busy     (out_busy),
        .out_done     (out_done),
        .out_flags    (out_flags)
    );

    // Free-running clock.
    always #5 in_clk = ~in_clk;

    task automatic checkWord(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic checkBit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Reference: result, {zero,negative,carry,overflow} and CALC cycle count.
    function automatic void refModel(input logic [2:0] op, input logic [W-1:0] a,
                                     input logic [W-1:0] b, output logic [W-1:0] res,
                                     output logic [3:0] flags, output int calc);
        longint full;
        int     sr;
        int     k;
        logic   c;
        logic   v;
        c    = 1'b0;
        v    = 1'b0;
        calc = 1;
        k    = int'(b[$clog2(W)-1:0]);
        res  = '0;
        case (op)
            3'd0: begin
                full = longint'(a) + longint'(b);
                res  = full[W-1:0];
                c    = full > 65535;
                sr   = int'($signed(a)) + int'($signed(b));
                v    = (sr > 32767) || (sr < -32768);
            end
            3'd1: begin
                full = longint'(a) - longint'(b);
                res  = full[W-1:0];
                c    = a < b;
                sr   = int'($signed(a)) - int'($signed(b));
                v    = (sr > 32767) || (sr < -32768);
            end
            3'd2: res = a & b;
            3'd3: res = a | b;
            3'd4: res = a ^ b;
            3'd5: begin
                res  = a << k;
                c    = (k != 0) && (((int'(a) >> (W - k)) & 1) != 0);
                calc = (k == 0) ? 1 : k;
            end
            3'd6: begin
                res  = a >> k;
                c    = (k != 0) && (((int'(a) >> (k - 1)) & 1) != 0);
                calc = (k == 0) ? 1 : k;
            end
            default: begin
                full = longint'(a) * longint'(b);
                res  = full[W-1:0];
                c    = (full >> W) != 0;
                calc = W;
            end
        endcase
        flags = {(res == '0), res[W-1], c, v};
    endfunction

    // Issue one op; when noisy, scramble start/operands while busy.
    task automatic applyStimulus(input logic [2:0] op, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input bit noisy);
        logic [W-1:0] expRes;
        logic [3:0]   expFlags;
        int           calc;
        int           n;
        bit           busyOk;
        refModel(op, a, b, expRes, expFlags, calc);
        @(negedge in_clk);
        in_alu_op    = op;
        in_operand_1 = a;
        in_operand_2 = b;
        in_start     = 1'b1;
        @(posedge in_clk);
        #1;
        checkBit("busyAfterAccept", out_busy, 1'b1);
        checkWord("holdResult", 32'(out_result), 32'(prevResult));
        checkWord("holdFlags", 32'(out_flags), 32'(prevFlags));
        in_start = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
        if (noisy) begin
            in_operand_1 = W'($urandom);
            in_operand_2 = W'($urandom);
            in_alu_op    = 3'($urandom_range(0, 7));
        end
        n      = 0;
        busyOk = 1'b1;
        while (!out_done && n < 200) begin
            @(posedge in_clk);
            #1;
            n++;
            if (!out_busy) busyOk = 1'b0;
            if (noisy && !out_done) begin
                in_start     = ~in_start;
                in_operand_1 = W'($urandom);
                in_operand_2 = W'($urandom);
                in_alu_op    = 3'($urandom_range(0, 7));
            end
        end
        checkWord("latency", 32'(n), 32'(calc));
        checkBit("busyThroughout", busyOk, 1'b1);
        checkOutput(expRes, expFlags);
        in_start = 1'b1;
        @(posedge in_clk);
        #1;
        in_start = 1'b0;
        checkBit("doneOnePulse", out_done, 1'b0);
        checkBit("idleAfterDone", out_busy, 1'b0);
        checkWord("resultHeld", 32'(out_result), 32'(expRes));
        prevResult = expRes;
        prevFlags  = expFlags;
    endtask

    task automatic checkOutput(input logic [W-1:0] expRes, input logic [3:0] expFlags);
        checkWord("result", 32'(out_result), 32'(expRes));
        checkWord("flags", 32'(out_flags), 32'(expFlags));
    endtask

    // Directed sequence, reset abort, then randomized traffic.
    initial begin
        int doneSeen;
        #2 in_rst_n = 1'b0;
        #2;
        checkWord("rstResult", 32'(out_result), 32'h0);
        checkWord("rstFlags", 32'(out_flags), 32'h0);
        checkBit("rstBusy", out_busy, 1'b0);
        checkBit("rstDone", out_done, 1'b0);
        repeat (2) @(negedge in_clk);
        in_rst_n = 1'b1;

        applyStimulus(3'd0, 16'h7FFF, 16'h0001, 1'b0);
        checkWord("add7fffFlags", 32'(out_flags), 32'h5);
        applyStimulus(3'd1, 16'h0003, 16'h0005, 1'b0);
        checkWord("sub35Result", 32'(out_result), 32'hFFFE);
        applyStimulus(3'd1, 16'h1234, 16'h1234, 1'b0);
        applyStimulus(3'd5, 16'h8001, 16'h0004, 1'b0);
        checkWord("shlResult", 32'(out_result), 32'h0010);
        applyStimulus(3'd6, 16'h0001, 16'h0000, 1'b0);
        applyStimulus(3'd7, 16'h0100, 16'h0100, 1'b0);
        checkWord("mulWrapFlags", 32'(out_flags), 32'hA);
        applyStimulus(3'd7, 16'h00FF, 16'h0003, 1'b1);
        checkWord("mulResult", 32'(out_result), 32'h02FD);
        applyStimulus(3'd2, 16'hF0F0, 16'h3C3C, 1'b0);

        @(negedge in_clk);
        in_alu_op    = 3'd7;
        in_operand_1 = 16'h1234;
        in_operand_2 = 16'h5678;
        in_start     = 1'b1;
        @(posedge in_clk);
        #1;
        in_start = 1'b0;
        repeat (7) @(posedge in_clk);
        #3;
        in_rst_n = 1'b0;
        #1;
        checkWord("abortResult", 32'(out_result), 32'h0);
        checkWord("abortFlags", 32'(out_flags), 32'h0);
        checkBit("abortBusy", out_busy, 1'b0);
        checkBit("abortDone", out_done, 1'b0);
        @(negedge in_clk);
        in_rst_n = 1'b1;
        doneSeen = 0;
        repeat (24) begin
            @(posedge in_clk);
            #1;
            if (out_done) doneSeen++;
        end
        checkWord("noDoneAfterAbort", 32'(doneSeen), 32'h0);
        prevResult = '0;
        prevFlags  = '0;
        applyStimulus(3'd0, 16'h8000, 16'h8000, 1'b0);

        for (int i = 0; i < 30; i++) begin
            applyStimulus(3'($urandom_range(0, 7)), W'($urandom), W'($urandom), (i % 2) == 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_execute_unit.md
ALU_EXECUTE_UNIT -- requirements
Module: alu_execute_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning operand/result width; shift amount field width is log2(WIDTH).
REQ-002 The block SHALL have port in_clk, input, 1, single clock; all state updates on rising edge.
REQ-003 The block SHALL have port in_rst_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port in_operand_1, input, WIDTH, first operand (register file).
REQ-005 The block SHALL have port in_operand_2, input, WIDTH, second operand (output of operand-2 select mux).
REQ-006 The block SHALL have port in_alu_op, input, 3, operation: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL, 6 SHR (logical), 7 MUL (low WIDTH bits).
REQ-007 The block SHALL have port in_start, input, 1, request to begin an operation.
REQ-008 The block SHALL have port out_result, output, WIDTH, registered result.
REQ-009 The block SHALL have port out_busy, output, 1, high while an operation is in progress.
REQ-010 The block SHALL have port out_done, output, 1, one-cycle completion pulse.
REQ-011 The block SHALL have port out_flags, output, 4, registered {zero, negative, carry, overflow}.

Function
REQ-012 FSM states SHALL be IDLE, CALC, DONE; out_busy = (state != IDLE).
REQ-013 In IDLE, in_start=1 at an edge SHALL latch in_operand_1, in_operand_2, in_alu_op and move to CALC.
REQ-014 in_start SHALL be ignored in CALC and DONE; latched operands SHALL not change mid-operation.
REQ-015 ADD/SUB/AND/OR/XOR SHALL spend exactly 1 cycle in CALC.
REQ-016 SHL/SHR SHALL shift one bit per cycle for k = operand_2[log2(WIDTH)-1:0] cycles in CALC; k=0 SHALL spend 1 cycle in CALC with result = operand_1.
REQ-017 MUL SHALL be iterative shift-add, exactly WIDTH cycles in CALC, result = low WIDTH bits of unsigned product.
REQ-018 On leaving CALC the block SHALL register out_result and out_flags and enter DONE; out_done SHALL be high only in DONE (one cycle); DONE SHALL return to IDLE on the next edge.
REQ-019 Total latency from accepting edge to out_done high SHALL be 1 + CALC cycles (ADD: out_done high in the 2nd cycle after the accepting edge).
REQ-020 out_result and out_flags SHALL hold their values until the next completion overwrites them.
REQ-021 zero = (result == 0); negative = result[WIDTH-1].
REQ-022 carry: ADD carry-out; SUB borrow (1 when operand_1 < operand_2 unsigned); SHL/SHR last bit shifted out (0 when k=0); MUL 1 if upper WIDTH product bits nonzero; logic ops 0.
REQ-023 overflow: ADD/SUB two's-complement signed overflow; all other ops 0.
REQ-024 ADD/SUB SHALL wrap modulo 2^WIDTH.
REQ-025 in_start asserted on the edge DONE returns to IDLE SHALL not be accepted; acceptance requires state IDLE at that edge.

Reset
REQ-026 in_rst_n low SHALL immediately force state IDLE, out_result 0, out_flags 0, out_busy 0, out_done 0, and clear iteration counters, regardless of clock.
REQ-027 Reset asserted mid-operation SHALL abort it with no out_done pulse; first start after in_rst_n rises SHALL behave as from power-up.

Verification
REQ-028 ADD 0x7FFF + 0x0001, start for 1 cycle -> out_done in 2nd cycle, out_result 0x8000, flags {z0,n1,c0,v1}.
REQ-029 SUB 0x0003 - 0x0005 -> out_result 0xFFFE, flags {z0,n1,c1,v0}; SUB 0x1234-0x1234 -> 0x0000, zero=1.
REQ-030 SHL 0x8001 by 4 -> out_busy 5 cycles, out_done 5 cycles after accept, result 0x0010, carry 0; SHR 0x0001 by 0 -> result 0x0001, carry 0, latency 2.
REQ-031 MUL 0x0100 * 0x0100 -> latency 17 cycles, result 0x0000, zero=1, carry=1; MUL 0x00FF*0x0003 -> 0x02FD, carry 0.
REQ-032 in_start toggled every cycle during MUL -> only first request accepted, exactly one out_done; in_rst_n pulsed low at CALC cycle 8 -> all outputs 0 immediately, no out_done.
